// File: rtl/fir_mc.sv
// fir_mc: time-multiplexed multi-channel FIR filter.
// One multiplier and one accumulator are shared by every channel.
// Each channel has its own circular delay line. All channels share one coefficient set.
// After an accepted sample, N_TAPS MAC cycles run, then one OUT cycle.
// data_out/out_ch are captured as the MAC sequence finishes and hold until the next result.
module fir_mc #(
    parameter int WD_IN   = 24,
    parameter int WD_OUT  = 24,
    parameter int WD_COEF = 16,
    parameter int N_TAPS  = 16,
    parameter int N_CH    = 2,
    parameter int FRAC    = 15,
    localparam int CHW    = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int TAPW   = $clog2(N_TAPS)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CHW-1:0]     in_ch,
    input  logic [WD_IN-1:0]   data_in,
    output logic               out_valid,
    output logic [CHW-1:0]     out_ch,
    output logic [WD_OUT-1:0]  data_out,
    input  logic               coef_we,
    input  logic [TAPW-1:0]    coef_addr,
    input  logic [WD_COEF-1:0] coef_data,
    output logic               busy
);

    localparam int WP = WD_IN + WD_COEF;           // product width
    localparam int WA = WP + $clog2(N_TAPS);       // accumulator width, wide enough for N_TAPS products
    localparam int WR = WA + 1;                    // headroom for the rounding add

    localparam logic [WD_COEF-1:0]  C_MAX = {1'b0, {(WD_COEF-1){1'b1}}};
    // Identity coefficient 2^FRAC, clipped to the largest positive coefficient.
    localparam logic [WD_COEF-1:0]  C_ID  = (FRAC >= WD_COEF-1) ? C_MAX : (WD_COEF'(1) << FRAC);
    localparam logic signed [WR-1:0] O_MAX = WR'({1'b0, {(WD_OUT-1){1'b1}}});
    localparam logic signed [WR-1:0] O_MIN = ~O_MAX;
    localparam logic signed [WR-1:0] RND   = WR'(1) << (FRAC-1);
    localparam logic [TAPW-1:0]      LAST  = TAPW'(N_TAPS-1);
    localparam logic [CHW:0]         NCH   = (CHW+1)'(N_CH);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t r_state, w_nxt;

    logic [N_CH-1:0][N_TAPS-1:0][WD_IN-1:0] r_dline;
    logic [N_CH-1:0][TAPW-1:0]              r_wptr;
    logic [N_TAPS-1:0][WD_COEF-1:0]         r_coef;
    logic [CHW-1:0]                         r_ch;
    logic [TAPW-1:0]                        r_rd;
    logic [TAPW-1:0]                        r_cnt;
    logic signed [WA-1:0]                   r_acc;
    logic                                   r_rdy_en;
    logic [WD_OUT-1:0]                      r_dout;
    logic [CHW-1:0]                         r_och;

    logic                  w_ch_ok, w_xfer, w_take, w_last;
    logic signed [WP-1:0]  w_prod;
    logic signed [WA-1:0]  w_acc_nxt;
    logic signed [WR-1:0]  w_rnd, w_sh;
    logic [WD_OUT-1:0]     w_sat;

    // r_rdy_en keeps in_ready low until the first edge after reset release.
    assign in_ready  = r_rdy_en & (r_state == S_IDLE) & ~clr;
    assign w_ch_ok   = {1'b0, in_ch} < NCH;
    assign w_xfer    = in_valid & in_ready;
    assign w_take    = w_xfer & w_ch_ok;     // out-of-range channels are consumed and dropped
    assign w_last    = (r_cnt == LAST);

    // r_rd walks backwards from the newest sample, so tap k sees x[n-k].
    assign w_prod    = $signed(r_coef[r_cnt]) * $signed(r_dline[r_ch][r_rd]);
    assign w_acc_nxt = r_acc + WA'(w_prod);
    assign w_rnd     = WR'(w_acc_nxt) + RND;
    assign w_sh      = w_rnd >>> FRAC;

    assign data_out  = r_dout;
    assign out_ch    = r_och;

    // Clamp the rounded, scaled sum to the output range.
    always_comb begin
        w_sat = w_sh[WD_OUT-1:0];
        if (w_sh > O_MAX)
            w_sat = O_MAX[WD_OUT-1:0];
        else if (w_sh < O_MIN)
            w_sat = O_MIN[WD_OUT-1:0];
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_nxt;
    end

    // Next state and status outputs. clr overrides everything and returns to IDLE.
    always_comb begin
        w_nxt     = r_state;
        busy      = (r_state != S_IDLE);
        out_valid = (r_state == S_OUT) & ~clr;
        case (r_state)
            S_IDLE:  if (w_take) w_nxt = S_MAC;
            S_MAC:   if (w_last) w_nxt = S_OUT;
            S_OUT:   w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
        if (clr)
            w_nxt = S_IDLE;
    end

    // Coefficients: writable only in IDLE. A write on a transfer edge feeds the MAC sequence starting there.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_coef    <= '0;
            r_coef[0] <= C_ID;
        end else if (coef_we && r_state == S_IDLE) begin
            r_coef[coef_addr] <= coef_data;
        end
    end

    // Delay lines, MAC sequencing and result capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdy_en <= 1'b0;
            r_dline  <= '0;
            r_wptr   <= '0;
            r_ch     <= '0;
            r_rd     <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_dout   <= '0;
            r_och    <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            if (clr) begin
                r_dline <= '0;
                r_wptr  <= '0;
            end else if (w_take) begin
                r_dline[in_ch][r_wptr[in_ch]] <= data_in;
                r_wptr[in_ch] <= (r_wptr[in_ch] == LAST) ? '0 : r_wptr[in_ch] + 1'b1;
                r_ch  <= in_ch;
                r_rd  <= r_wptr[in_ch];
                r_cnt <= '0;
                r_acc <= '0;
            end else if (r_state == S_MAC) begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt + 1'b1;
                r_rd  <= (r_rd == '0) ? LAST : r_rd - 1'b1;
                if (w_last) begin
                    r_dout <= w_sat;
                    r_och  <= r_ch;
                end
            end
        end
    end

endmodule
